pattern_scan_controller: RTL and testbench

//  Byte-stream front end and sequencer for serial pattern detection. Accepts bytes over a

---
 rtl/pattern_scan_controller.sv | 170 +++++++++++++++++
 tb/tb_pattern_scan_controller.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_scan_controller.sv
// Byte-stream front end that serialises bytes MSB-first into a programmable
// serial pattern matcher, counting matches and stopping at a match target.
module pattern_scan_controller #(
    parameter int PAT_MAX = 8,
    parameter int CNT_W   = 8,
    localparam int LEN_W  = $clog2(PAT_MAX) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [PAT_MAX-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               abort,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               bit_valid,
    output logic               bit_out,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy,
    output logic               done,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    logic [PAT_MAX-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [CNT_W-1:0]   tgt_q;
    logic [PAT_MAX-1:0] hist;
    logic [LEN_W-1:0]   fill;
    logic [7:0]         shreg;
    logic [2:0]         bit_idx;

    logic [LEN_W-1:0]   len_eff;
    logic [PAT_MAX-1:0] hist_next;
    logic [PAT_MAX-1:0] len_mask;
    logic [LEN_W-1:0]   fill_inc;
    logic [LEN_W-1:0]   fill_after;
    logic [CNT_W-1:0]   count_next;
    logic               hit;
    logic               target_hit;

    assign state_dbg = state;

    // A zero length would never match; oversize lengths cannot exceed the history.
    always_comb begin
        if (cfg_len == '0) begin
            len_eff = LEN_W'(1);
        end else if (cfg_len > LEN_W'(PAT_MAX)) begin
            len_eff = LEN_W'(PAT_MAX);
        end else begin
            len_eff = cfg_len;
        end
    end

    always_comb begin
        hist_next = {hist[PAT_MAX-2:0], bit_out};
        fill_inc  = (fill == LEN_W'(PAT_MAX)) ? fill : fill + 1'b1;
        for (int i = 0; i < PAT_MAX; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
        hit        = (fill_inc >= len_q) && ((hist_next & len_mask) == (pat_q & len_mask));
        fill_after = (hit && !ovl_q) ? '0 : fill_inc;
        count_next = match_count;
        if (hit && (match_count != '1)) begin
            count_next = match_count + 1'b1;
        end
        target_hit = hit && (tgt_q != '0) && (count_next == tgt_q);
    end

    // Byte handshake: a byte transfers on a rising edge where in_valid and in_ready
    // are both high; in_ready is high only while ARMED and in_data is taken as is.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pat_q       <= '0;
            len_q       <= LEN_W'(1);
            ovl_q       <= 1'b1;
            tgt_q       <= '0;
            hist        <= '0;
            fill        <= '0;
            shreg       <= '0;
            bit_idx     <= '0;
            match_count <= '0;
            in_ready    <= 1'b0;
            bit_valid   <= 1'b0;
            bit_out     <= 1'b0;
            match       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            match <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                in_ready  <= 1'b0;
                bit_valid <= 1'b0;
                bit_out   <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (cfg_we && (state == IDLE)) begin
                            pat_q <= cfg_pattern;
                            len_q <= len_eff;
                            ovl_q <= cfg_overlap;
                            tgt_q <= cfg_target;
                        end
                        if (start) begin
                            state       <= ARMED;
                            hist        <= '0;
                            fill        <= '0;
                            match_count <= '0;
                            in_ready    <= 1'b1;
                            bit_valid   <= 1'b0;
                            bit_out     <= 1'b0;
                            busy        <= 1'b1;
                            done        <= 1'b0;
                        end
                    end
                    ARMED: begin
                        if (in_valid) begin
                            state     <= SHIFT;
                            shreg     <= in_data;
                            bit_idx   <= 3'd7;
                            in_ready  <= 1'b0;
                            bit_valid <= 1'b1;
                            bit_out   <= in_data[7];
                        end
                    end
                    SHIFT: begin
                        hist        <= hist_next;
                        fill        <= fill_after;
                        match       <= hit;
                        match_count <= count_next;
                        if (target_hit) begin
                            state     <= DONE;
                            bit_valid <= 1'b0;
                            bit_out   <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else if (bit_idx == 3'd0) begin
                            state     <= ARMED;
                            in_ready  <= 1'b1;
                            bit_valid <= 1'b0;
                            bit_out   <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx - 3'd1;
                            bit_out <= shreg[bit_idx - 3'd1];
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pattern_scan_controller.sv
// Directed bench for pattern_scan_controller: a queue-based model predicts every
// output each cycle, and literal expectations pin the model on the key scenarios.
module tb_pattern_scan_controller;

    localparam int PAT_MAX = 8;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = $clog2(PAT_MAX) + 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_SHIFT = 2;
    localparam int M_DONE  = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic               cfg_we;
    logic [PAT_MAX-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_target;
    logic               start;
    logic               abort;
    logic               in_valid;
    logic [7:0]         in_data;
    logic               in_ready;
    logic               bit_valid;
    logic               bit_out;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic               busy;
    logic               done;
    logic [1:0]         state_dbg;

    pattern_scan_controller #(.PAT_MAX(PAT_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
        .start(start), .abort(abort), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .bit_valid(bit_valid), .bit_out(bit_out), .match(match),
        .match_count(match_count), .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: run mode, bits of the current byte still to appear, bits seen since clear.
    int                 m_mode = M_IDLE;
    logic [0:0]         exp_q[$];
    bit                 m_hist[$];
    int                 m_count = 0;
    bit                 m_match = 1'b0;
    logic [PAT_MAX-1:0] m_pat = '0;
    int                 m_len = 1;
    bit                 m_ovl = 1'b1;
    int                 m_tgt = 0;
    int                 match_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_arm();
        m_mode  = M_ARMED;
        m_hist.delete();
        m_count = 0;
    endtask

    task automatic model_step();
        bit hit;
        int n;
        m_match = 1'b0;
        if (reset) begin
            m_mode = M_IDLE; m_pat = '0; m_len = 1; m_ovl = 1'b1; m_tgt = 0;
            m_hist.delete(); exp_q.delete(); m_count = 0;
        end else if (abort) begin
            m_mode = M_IDLE;
            exp_q.delete();
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (cfg_we) begin
                        m_pat = cfg_pattern;
                        m_len = (cfg_len == 0) ? 1 : ((cfg_len > PAT_MAX) ? PAT_MAX : int'(cfg_len));
                        m_ovl = cfg_overlap;
                        m_tgt = int'(cfg_target);
                    end
                    if (start) model_arm();
                end
                M_DONE: if (start) model_arm();
                M_ARMED: begin
                    if (in_valid) begin
                        for (int i = 7; i >= 0; i--) exp_q.push_back(in_data[i]);
                        m_mode = M_SHIFT;
                    end
                end
                default: begin
                    m_hist.push_back(exp_q.pop_front());
                    if (m_hist.size() > PAT_MAX) void'(m_hist.pop_front());
                    n = m_hist.size();
                    hit = (n >= m_len);
                    if (hit) begin
                        for (int j = 0; j < m_len; j++) begin
                            if (m_hist[n - m_len + j] != m_pat[m_len - 1 - j]) hit = 1'b0;
                        end
                    end
                    if (hit) begin
                        m_match = 1'b1;
                        if (m_count < CNT_MAX) m_count++;
                        if (!m_ovl) m_hist.delete();
                        if (m_tgt != 0 && m_count == m_tgt) begin
                            m_mode = M_DONE;
                            exp_q.delete();
                        end
                    end
                    if (m_mode == M_SHIFT && exp_q.size() == 0) m_mode = M_ARMED;
                end
            endcase
        end
    endtask

    task automatic compare();
        check("in_ready", in_ready, m_mode == M_ARMED);
        check("busy", busy, (m_mode == M_ARMED) || (m_mode == M_SHIFT));
        check("done", done, m_mode == M_DONE);
        check("bit_valid", bit_valid, m_mode == M_SHIFT);
        check("bit_out", bit_out, (m_mode == M_SHIFT && exp_q.size() > 0) ? exp_q[0] : 1'b0);
        check("match", match, m_match);
        check("match_count", match_count, m_count);
        if (match === 1'b1) match_cyc.push_back(cyc);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        cyc++;
        #1;
        compare();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic configure(input logic [7:0] pat, input int len, input bit ovl, input int tgt);
        cfg_pattern = pat; cfg_len = LEN_W'(len); cfg_overlap = ovl; cfg_target = CNT_W'(tgt);
        cfg_we = 1'b1;
        cycle();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; cycle(); start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1; cycle(); abort = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output int hs);
        int n;
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            cycle();
            n++;
        end
        if (n >= 50) check("handshake_timeout", 0, 1);
        cycle();
        hs = cyc;
        in_valid = 1'b0;
    endtask

    initial begin
        int hs;
        int hs2;
        reset = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        cfg_target = '0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
        run(2);
        check("rst_busy", busy, 0);
        check("rst_count", match_count, 0);
        reset = 1'b0;
        cycle();

        // Overlapping 10010 over 0x92: hits on the 5th and 8th bit.
        configure(8'b0001_0010, 5, 1'b1, 0);
        pulse_start();
        match_cyc.delete();
        send_byte(8'h92, hs);
        run(10);
        check("t1_count", match_count, 2);
        check("t1_pulses", match_cyc.size(), 2);
        if (match_cyc.size() == 2) begin
            check("t1_first_at", match_cyc[0] - hs, 5);
            check("t1_second_at", match_cyc[1] - hs, 8);
        end
        check("t1_ready", in_ready, 1);

        pulse_abort();
        configure(8'b0001_0010, 5, 1'b0, 0);
        pulse_start();
        match_cyc.delete();
        send_byte(8'h92, hs);
        run(10);
        check("t2_count", match_count, 1);
        check("t2_pulses", match_cyc.size(), 1);

        // Non-overlapping run across a byte boundary; start in ARMED is ignored.
        pulse_abort();
        pulse_start();
        pulse_start();
        match_cyc.delete();
        send_byte(8'h09, hs);
        send_byte(8'h20, hs2);
        run(10);
        check("t3_gap", hs2 - hs, 9);
        check("t3_count", match_count, 1);
        if (match_cyc.size() == 1) check("t3_at", match_cyc[0] - hs2, 1);
        else check("t3_pulses", match_cyc.size(), 1);

        pulse_abort();
        configure(8'h01, 1, 1'b1, 3);
        pulse_start();
        match_cyc.delete();
        send_byte(8'hFF, hs);
        run(6);
        check("t4_done", done, 1);
        check("t4_count", match_count, 3);
        check("t4_pulses", match_cyc.size(), 3);
        check("t4_bit_valid", bit_valid, 0);
        pulse_start();
        check("t4_restart_count", match_count, 0);
        check("t4_restart_ready", in_ready, 1);

        // Abort in the 4th shift cycle: only three bits are consumed.
        pulse_abort();
        configure(8'h01, 1, 1'b1, 0);
        pulse_start();
        send_byte(8'hF0, hs);
        run(3);
        pulse_abort();
        check("t5_bit_valid", bit_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_count", match_count, 3);
        run(3);
        check("t5_count_held", match_count, 3);

        pulse_start();
        send_byte(8'hFF, hs);
        run(2);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("t5_rst_valid", bit_valid, 0);
        check("t5_rst_count", match_count, 0);
        check("t5_rst_busy", busy, 0);
        pulse_start();
        send_byte(8'h0F, hs);
        run(10);
        check("t5_default_cfg", match_count, 4);

        pulse_abort();
        configure(8'b0001_0010, 5, 1'b1, 0);
        pulse_start();
        configure(8'h00, 1, 1'b1, 0);
        send_byte(8'h92, hs);
        run(10);
        check("t6_cfg_ignored", match_count, 2);

        pulse_abort();
        configure(8'h01, 0, 1'b1, 0);
        pulse_start();
        send_byte(8'hA5, hs);
        run(10);
        check("t6_len0", match_count, 4);

        pulse_abort();
        configure(8'h5A, 15, 1'b1, 0);
        pulse_start();
        send_byte(8'h5A, hs);
        run(10);
        check("t6_len_clamp", match_count, 1);

        pulse_abort();
        configure(8'h01, 1, 1'b1, 0);
        pulse_start();
        match_cyc.delete();
        for (int i = 0; i < 38; i++) send_byte(8'hFF, hs);
        run(10);
        check("t6_sat_count", match_count, 255);
        check("t6_sat_pulses", match_cyc.size(), 304);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
